// File: rtl/rom_rd_arbiter_if.sv
// Requester/ROM-side bundle for rom_rd_arbiter.
// slave = arbiter view, master = clients plus the ROM macro.
interface rom_rd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 3,
  parameter int DW    = 16,
  parameter int LW    = 3,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*LW-1:0] req_len;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic                rom_cs;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic [DW-1:0]       rd_data;
  logic                rd_valid;
  logic [IDW-1:0]      rd_id;
  logic                rd_last;

  modport slave (
    input  req,
    input  req_addr,
    input  req_len,
    input  rom_data,
    output gnt,
    output busy,
    output rom_cs,
    output rom_addr,
    output rd_data,
    output rd_valid,
    output rd_id,
    output rd_last
  );

  modport master (
    output req,
    output req_addr,
    output req_len,
    output rom_data,
    input  gnt,
    input  busy,
    input  rom_cs,
    input  rom_addr,
    input  rd_data,
    input  rd_valid,
    input  rd_id,
    input  rd_last
  );
endinterface

// File: rtl/rom_rd_arbiter.sv
// Round-robin burst arbiter in front of a registered-output ROM.
// Bursts issue one address per cycle; data returns tagged one cycle later.
module rom_rd_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 3,
  parameter int DW    = 16,
  parameter int LW    = 3,
  parameter int IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  rom_rd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] win;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  sel_addr;
  logic [LW-1:0]  cnt_q;
  logic [LW-1:0]  sel_len;
  logic           first_q;
  logic           found;
  logic           issue;
  logic           last_issue;
  logic           arb;

  // Two passes: requesters above ptr first, then wrap to the rest.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[i] && i > int'(ptr_q)) begin
        found    = 1'b1;
        win      = IDW'(i);
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_len  = bus.req_len[i*LW +: LW];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[i] && i <= int'(ptr_q)) begin
        found    = 1'b1;
        win      = IDW'(i);
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_len  = bus.req_len[i*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   if (cnt_q == '0) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = 1'b0;
    bus.rom_cs = 1'b0;
    bus.gnt    = '0;
    unique case (1'b1)
      (state_q == ISSUE): begin
        bus.busy   = 1'b1;
        bus.rom_cs = 1'b1;
      end
      (state_q == DRAIN): bus.busy = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < N_REQ; i++)
      bus.gnt[i] = issue && first_q && (id_q == IDW'(i));
  end

  assign issue       = (state_q == ISSUE);
  assign last_issue  = issue && (cnt_q == '0);
  assign arb         = (state_q == IDLE) && found;
  assign bus.rom_addr = addr_q;
  assign bus.rd_data  = bus.rom_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IDW'(N_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= arb;
      if (arb) begin
        ptr_q  <= win;
        id_q   <= win;
        addr_q <= sel_addr;
        cnt_q  <= sel_len;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  // Return tags follow the ROM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.rd_id    <= '0;
    end else begin
      bus.rd_valid <= issue;
      bus.rd_last  <= last_issue;
      bus.rd_id    <= id_q;
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a behavioural 8x16 ROM.
// Each task steps cycle by cycle against hand-built expected vectors.
module tb_rom_rd_arbiter;

  logic clk;
  logic rst;
  int   compares = 0;
  int   fails    = 0;

  rom_rd_arbiter_if #(
    .N_REQ(4), .AW(3), .DW(16), .LW(3), .IDW(2)
  ) bus ();

  rom_rd_arbiter #(
    .N_REQ(4), .AW(3), .DW(16), .LW(3), .IDW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: mem[i] = A000 + i, registered read.
  always @(posedge clk)
    if (bus.rom_cs) bus.rom_data <= 16'hA000 + {13'd0, bus.rom_addr};

  // {gnt, busy, cs, addr, valid, last, id, data}
  function automatic logic [28:0] ev(
    input logic [3:0] g, input logic b, input logic cs,
    input logic [2:0] a, input logic v, input logic l,
    input logic [1:0] id, input logic [15:0] d);
    return {g, b, cs, a, v, l, id, d};
  endfunction

  function automatic logic [28:0] obs();
    logic v;
    v = bus.rd_valid;
    return {bus.gnt, bus.busy, bus.rom_cs,
            bus.rom_cs ? bus.rom_addr : 3'd0,
            v, bus.rd_last,
            v ? bus.rd_id : 2'd0,
            v ? bus.rd_data : 16'd0};
  endfunction

  task automatic set_req(input int i, input logic [2:0] a,
                         input logic [2:0] l);
    bus.req_addr[i*3 +: 3] = a;
    bus.req_len[i*3 +: 3]  = l;
    bus.req[i]             = 1'b1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    @(negedge clk);
    compares++;
    if (obs() !== 29'd0) begin
      fails++;
      $display("FAIL reset_out got %h want %h", obs(), 29'd0);
    end
    compares++;
    if ({bus.rom_addr, bus.rd_id} !== 5'd0) begin
      fails++;
      $display("FAIL reset_addr_id got %h want 0",
               {bus.rom_addr, bus.rd_id});
    end
    rst = 1'b0;
    @(negedge clk);
    compares++;
    if (obs() !== 29'd0) begin
      fails++;
      $display("FAIL reset_idle got %h want %h", obs(), 29'd0);
    end
  endtask

  task automatic test_single();
    logic [28:0] e [0:4];
    e[0] = ev(4'b0100, 1, 1, 3'd5, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 1, 3'd6, 1, 0, 2'd2, 16'hA005);
    e[2] = ev(4'b0000, 1, 1, 3'd7, 1, 0, 2'd2, 16'hA006);
    e[3] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd2, 16'hA007);
    e[4] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(2, 3'd5, 3'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL single c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
  endtask

  task automatic test_wrap();
    logic [28:0] e [0:5];
    e[0] = ev(4'b0001, 1, 1, 3'd6, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 1, 3'd7, 1, 0, 2'd0, 16'hA006);
    e[2] = ev(4'b0000, 1, 1, 3'd0, 1, 0, 2'd0, 16'hA007);
    e[3] = ev(4'b0000, 1, 1, 3'd1, 1, 0, 2'd0, 16'hA000);
    e[4] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd0, 16'hA001);
    e[5] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(0, 3'd6, 3'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL wrap c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
  endtask

  task automatic test_round_robin();
    logic [28:0] e [0:14];
    int id;
    for (int b = 0; b < 5; b++) begin
      id = b % 4;
      e[3*b]   = ev(4'(1 << id), 1, 1, 3'(id), 0, 0, 2'd0, 16'h0);
      e[3*b+1] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'(id),
                    16'hA000 + 16'(id));
      e[3*b+2] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 3'd0);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL rr c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 14) bus.req = '0;
    end
  endtask

  task automatic test_len_extremes();
    logic [28:0] e [0:9];
    e[0] = ev(4'b1000, 1, 1, 3'd4, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd3, 16'hA004);
    e[2] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(3, 3'd4, 3'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL len0 c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
    e[0] = ev(4'b0001, 1, 1, 3'd0, 0, 0, 2'd0, 16'h0);
    for (int k = 1; k < 8; k++)
      e[k] = ev(4'b0000, 1, 1, 3'(k), 1, 0, 2'd0,
                16'hA000 + 16'(k - 1));
    e[8] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd0, 16'hA007);
    e[9] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(0, 3'd0, 3'd7);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL len7 c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
  endtask

  task automatic test_ignored_inputs();
    logic [28:0] e [0:4];
    e[0] = ev(4'b0010, 1, 1, 3'd2, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 1, 3'd3, 1, 0, 2'd1, 16'hA002);
    e[2] = ev(4'b0000, 1, 1, 3'd4, 1, 0, 2'd1, 16'hA003);
    e[3] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd1, 16'hA004);
    e[4] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(1, 3'd2, 3'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL ignored c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) begin
        bus.req            = '0;
        bus.req_addr[5:3]  = 3'd7;
        bus.req_len[5:3]   = 3'd0;
      end
      if (c == 1) begin
        bus.req_addr[5:3]  = 3'd5;
        bus.req_len[5:3]   = 3'd6;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [28:0] e [0:2];
    e[0] = ev(4'b0100, 1, 1, 3'd0, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 1, 3'd1, 1, 0, 2'd2, 16'hA000);
    set_req(2, 3'd0, 3'd5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL midrst c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
    rst = 1'b1;
    #1;
    compares++;
    if (obs() !== 29'd0) begin
      fails++;
      $display("FAIL midrst_async got %h want %h", obs(), 29'd0);
    end
    compares++;
    if ({bus.rom_addr, bus.rd_id} !== 5'd0) begin
      fails++;
      $display("FAIL midrst_addr_id got %h want 0",
               {bus.rom_addr, bus.rd_id});
    end
    @(negedge clk);
    compares++;
    if (obs() !== 29'd0) begin
      fails++;
      $display("FAIL midrst_held got %h want %h", obs(), 29'd0);
    end
    e[0] = ev(4'b0010, 1, 1, 3'd3, 0, 0, 2'd0, 16'h0);
    e[1] = ev(4'b0000, 1, 0, 3'd0, 1, 1, 2'd1, 16'hA003);
    e[2] = ev(4'b0000, 0, 0, 3'd0, 0, 0, 2'd0, 16'h0);
    set_req(1, 3'd3, 3'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compares++;
      if (obs() !== e[c]) begin
        fails++;
        $display("FAIL postrst c%0d got %h want %h", c, obs(), e[c]);
      end
      if (c == 0) bus.req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_len_extremes();
    test_ignored_inputs();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, fails);
    $finish;
  end

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares one synchronous-read ROM between N_REQ requesters. The ROM is 8 x 16, has a chip select, and returns registered data.
- Each requester asks for a burst of 1-8 consecutive words. Bursts are granted round-robin.
- The block drives the ROM's cs/addr and returns tagged read data to all requesters on a common return bus.
- It sits between the ROM macro and its client blocks, replacing direct ROM connections.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 3, ROM address width (depth 2^AW).
- DW, 16, ROM data width.
- LW, 3, burst-length field width; encodes words-1, so 0 = 1 word and 7 = 8 words.
- IDW, 2, requester-ID width; must satisfy 2^IDW >= N_REQ.

Ports:
- clk, input, 1, single clock, rising-edge.
- rst, input, 1, asynchronous, active-high reset.
- req, input, N_REQ, per-requester request level.
- req_addr, input, N_REQ*AW, start address; requester i uses bits [i*AW +: AW].
- req_len, input, N_REQ*LW, burst length minus 1; requester i uses bits [i*LW +: LW].
- gnt, output, N_REQ, one-hot single-cycle grant pulse.
- busy, output, 1, high whenever the state is not IDLE.
- rom_cs, output, 1, ROM chip select.
- rom_addr, output, AW, ROM address.
- rom_data, input, DW, ROM read data, valid the cycle after rom_cs.
- rd_data, output, DW, return data; combinational pass-through of rom_data.
- rd_valid, output, 1, rd_data valid this cycle.
- rd_id, output, IDW, requester that owns the current rd_data.
- rd_last, output, 1, final word of the burst.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - State goes to IDLE.
  - gnt, busy, rom_cs, rd_valid, rd_last are 0; rom_addr and rd_id are 0.
  - The round-robin pointer is set to N_REQ-1, so requester 0 wins first.
  - Reset asserted mid-burst aborts the burst: outputs clear immediately, and no rd_valid is produced for words already issued.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, at a posedge with req != 0:
  - Select the first set req bit scanning upward from ptr+1 (mod N_REQ).
  - Latch that requester's addr, len and id.
  - Set ptr = winner and enter ISSUE.
  - gnt[winner] = 1 for exactly that first ISSUE cycle.
- ISSUE:
  - Every cycle: rom_cs = 1 and rom_addr = current address.
  - The address increments mod 2^AW, so it wraps 7 -> 0 and never saturates.
  - The remaining-word counter decrements each cycle.
  - After len+1 issue cycles, go to DRAIN.
- DRAIN:
  - rom_cs = 0; the last word returns this cycle.
  - Next state is IDLE; there is no arbitration in DRAIN.
- Burst timing: a burst of L words occupies L+1 busy cycles, with a minimum 1-cycle IDLE gap before the next grant.
- Return path:
  - rd_valid, rd_id and rd_last are registered copies of the issue-cycle rom_cs, id and last-issue flag, so they are delayed by 1 cycle.
  - rd_data = rom_data.
  - rd_valid is high for exactly L consecutive cycles per burst; rd_last is high only on the L-th.
- Request rules:
  - req, req_addr and req_len are sampled only in IDLE, at the arbitration edge.
  - Changes during ISSUE/DRAIN are ignored.
  - A requester keeps req high until it sees gnt. After gnt it drops req, or re-requests for a new burst.
  - A req dropped before being granted is lost, and is not an error.
- Simultaneous requests: round-robin guarantees each requester is granted within N_REQ bursts while it holds req.
- gnt never has more than one bit set. rom_cs is never high in IDLE or DRAIN.

Test Plan:
- Single burst: ROM model mem[i] = 16'hA000+i; req[2]=1, addr=5, len=2.
  - Expect gnt=4'b0100 for one cycle.
  - Expect rom_addr 5, 6, 7 on consecutive cycles.
  - Expect rd_data A005, A006, A007 with rd_id=2, and rd_last on A007.
- Wrap: req[0], addr=6, len=3.
  - Expect rom_addr 6, 7, 0, 1.
  - Expect rd_data A006, A007, A000, A001, with rd_last only on A001.
- Round-robin: all req held high after reset, each len=0.
  - Grant order is 0, 1, 2, 3, 0.
  - Each burst gives exactly one rd_valid, and the rd_id sequence matches the grant order.
- Length extremes: len=0 gives 1 rd_valid; len=7 from addr 0 gives 8 words, A000..A007, busy for 8 cycles then DRAIN, with rd_last on A007.
- Ignored inputs: change req_addr[1] and req_len[1] during ISSUE of requester 1's burst; the burst keeps its latched values.
- Reset mid-burst: assert rst on the 2nd ISSUE cycle of a len=5 burst.
  - All outputs go to 0 without waiting for a clock edge, and no further rd_valid appears.
  - After release with req[1]=1, requester 1 is granted once (ptr=3 scans 0, 1).
